// File: rtl/rv_rf_param.sv
// ---------------------------------------------------------------------------
// rv_rf_param
//
// Parametrised integer register file for the 3-stage RV32IMC pipeline.
// Two combinational read ports and one synchronous write port, with an
// optional hardwired zero register, optional same-cycle write-to-read bypass
// and a per-register pending scoreboard. Decode reads and allocates, and
// writeback writes. After reset an optional sweep zeroes every entry; the
// block reports busy while the sweep runs.
//
// Parameters:
//   XLEN        data width in bits
//   NREG        number of registers (>= 2)
//   ZERO_REG    1: register 0 reads 0, ignores writes, is never pending
//   BYPASS      1: a same-cycle write is forwarded to the read ports
//   CLR_ON_RST  1: sweep-clear every entry after reset
//
// Ports:
//   clk             clock, all state updates on the rising edge
//   rst             synchronous active-high reset
//   c_rf_write      write enable
//   rd_addr         write address
//   rd_dati         write data
//   c_rd_alloc      mark rd_alloc_addr as pending
//   rd_alloc_addr   register to mark as pending
//   rs1_addr        read port 1 address
//   rs1_dato_async  read port 1 data (combinational)
//   rs1_pend        read port 1 register has a result outstanding
//   rs2_addr        read port 2 address
//   rs2_dato_async  read port 2 data (combinational)
//   rs2_pend        read port 2 register has a result outstanding
//   rf_busy         reset or clear sweep in progress; ports are inert
// ---------------------------------------------------------------------------
module rv_rf_param #(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1,
    parameter int CLR_ON_RST = 1,
    localparam int AW        = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            c_rf_write,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] rd_dati,
    input  logic            c_rd_alloc,
    input  logic [AW-1:0]   rd_alloc_addr,
    input  logic [AW-1:0]   rs1_addr,
    output logic [XLEN-1:0] rs1_dato_async,
    output logic            rs1_pend,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs2_dato_async,
    output logic            rs2_pend,
    output logic            rf_busy
);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    // One extra bit so that an address equal to NREG can be compared when
    // NREG is a power of two.
    localparam logic [AW:0]   NREG_W   = (AW + 1)'(NREG);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    state_t            state;
    logic [AW-1:0]     idx;
    logic [NREG-1:0]   pend;
    logic [XLEN-1:0]   rf [NREG];

    logic busy;
    logic wr_valid;
    logic alloc_valid;
    logic rd1_ok;
    logic rd2_ok;
    logic byp1;
    logic byp2;

    // An address is usable when it names a real entry and is not the
    // hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < NREG_W) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Busy follows rst directly so that the ports go inert in the same cycle
    // reset is raised, not one cycle later.
    assign busy        = rst || (state == CLEAR);
    assign rf_busy     = busy;
    assign wr_valid    = !busy && c_rf_write && addr_ok(rd_addr);
    assign alloc_valid = !busy && c_rd_alloc && addr_ok(rd_alloc_addr);

    assign rd1_ok = !busy && addr_ok(rs1_addr);
    assign rd2_ok = !busy && addr_ok(rs2_addr);
    assign byp1   = (BYPASS != 0) && wr_valid && (rd_addr == rs1_addr);
    assign byp2   = (BYPASS != 0) && wr_valid && (rd_addr == rs2_addr);

    // Sequencer and scoreboard. The alloc assignment comes after the write
    // clear so that an allocation to the register being written in the same
    // cycle leaves the bit set.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= (CLR_ON_RST != 0) ? CLEAR : READY;
            idx   <= '0;
            pend  <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (idx == LAST_IDX) begin
                        state <= READY;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                READY: begin
                    if (wr_valid) begin
                        pend[rd_addr] <= 1'b0;
                    end
                    if (alloc_valid) begin
                        pend[rd_alloc_addr] <= 1'b1;
                    end
                end
                default: state <= READY;
            endcase
        end
    end

    // Storage array kept out of the reset branch so it maps onto plain RAM
    // or flops without a reset net; the sweep provides the clearing instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                rf[idx] <= '0;
            end else if (wr_valid) begin
                rf[rd_addr] <= rd_dati;
            end
        end
    end

    always_comb begin
        rs1_dato_async = '0;
        if (rd1_ok) begin
            rs1_dato_async = byp1 ? rd_dati : rf[rs1_addr];
        end
    end

    always_comb begin
        rs2_dato_async = '0;
        if (rd2_ok) begin
            rs2_dato_async = byp2 ? rd_dati : rf[rs2_addr];
        end
    end

    // A pending register that is being written this cycle is already
    // satisfied when its value is forwarded.
    assign rs1_pend = rd1_ok && pend[rs1_addr] && !byp1;
    assign rs2_pend = rd2_ok && pend[rs2_addr] && !byp2;

endmodule

// File: tb/tb_rv_rf_param.sv
// ---------------------------------------------------------------------------
// tb_rv_rf_param
//
// Self-checking bench for rv_rf_param. Four instances share one stimulus
// stream:
//   a: defaults (NREG=32, zero register, bypass, clear sweep)
//   b: no zero register, no bypass
//   c: NREG=24 (out-of-range addresses exist)
//   d: no clear sweep
// Expected values are pushed into a scoreboard queue when a step is driven
// and popped when the matching output is sampled, two time units after the
// falling edge on which inputs change.
// ---------------------------------------------------------------------------
module tb_rv_rf_param;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        c_rf_write;
    logic [4:0]  rd_addr;
    logic [31:0] rd_dati;
    logic        c_rd_alloc;
    logic [4:0]  rd_alloc_addr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;

    logic [3:0][31:0] d1;
    logic [3:0][31:0] d2;
    logic [3:0]       p1;
    logic [3:0]       p2;
    logic [3:0]       busy;

    exp_t sb[$];
    int   total;
    int   bad;
    int   cnt_a;
    int   cnt_b;
    int   cnt_c;
    int   cnt_d;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rv_rf_param u_a (
        .clk(clk), .rst(rst), .c_rf_write(c_rf_write), .rd_addr(rd_addr),
        .rd_dati(rd_dati), .c_rd_alloc(c_rd_alloc), .rd_alloc_addr(rd_alloc_addr),
        .rs1_addr(rs1_addr), .rs1_dato_async(d1[0]), .rs1_pend(p1[0]),
        .rs2_addr(rs2_addr), .rs2_dato_async(d2[0]), .rs2_pend(p2[0]),
        .rf_busy(busy[0])
    );

    rv_rf_param #(.ZERO_REG(0), .BYPASS(0)) u_b (
        .clk(clk), .rst(rst), .c_rf_write(c_rf_write), .rd_addr(rd_addr),
        .rd_dati(rd_dati), .c_rd_alloc(c_rd_alloc), .rd_alloc_addr(rd_alloc_addr),
        .rs1_addr(rs1_addr), .rs1_dato_async(d1[1]), .rs1_pend(p1[1]),
        .rs2_addr(rs2_addr), .rs2_dato_async(d2[1]), .rs2_pend(p2[1]),
        .rf_busy(busy[1])
    );

    rv_rf_param #(.NREG(24)) u_c (
        .clk(clk), .rst(rst), .c_rf_write(c_rf_write), .rd_addr(rd_addr),
        .rd_dati(rd_dati), .c_rd_alloc(c_rd_alloc), .rd_alloc_addr(rd_alloc_addr),
        .rs1_addr(rs1_addr), .rs1_dato_async(d1[2]), .rs1_pend(p1[2]),
        .rs2_addr(rs2_addr), .rs2_dato_async(d2[2]), .rs2_pend(p2[2]),
        .rf_busy(busy[2])
    );

    rv_rf_param #(.CLR_ON_RST(0)) u_d (
        .clk(clk), .rst(rst), .c_rf_write(c_rf_write), .rd_addr(rd_addr),
        .rd_dati(rd_dati), .c_rd_alloc(c_rd_alloc), .rd_alloc_addr(rd_alloc_addr),
        .rs1_addr(rs1_addr), .rs1_dato_async(d1[3]), .rs1_pend(p1[3]),
        .rs2_addr(rs2_addr), .rs2_dato_async(d2[3]), .rs2_pend(p2[3]),
        .rf_busy(busy[3])
    );

    // Drive one cycle's worth of inputs just after the falling edge.
    task automatic apply_stimulus(input logic r, input logic we, input logic [4:0] wa,
                                  input logic [31:0] wd, input logic al,
                                  input logic [4:0] aa, input logic [4:0] a1,
                                  input logic [4:0] a2);
        @(negedge clk);
        rst           = r;
        c_rf_write    = we;
        rd_addr       = wa;
        rd_dati       = wd;
        c_rd_alloc    = al;
        rd_alloc_addr = aa;
        rs1_addr      = a1;
        rs2_addr      = a2;
    endtask

    task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
        apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, a1, a2);
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check_output(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("[TB] FAIL scoreboard_underflow observed=%h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val)
            else begin
                bad++;
                $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cnt_a = 0;
        cnt_b = 0;
        cnt_c = 0;
        cnt_d = 0;
        rst = 1'b1; c_rf_write = 1'b0; rd_addr = '0; rd_dati = '0;
        c_rd_alloc = 1'b0; rd_alloc_addr = '0; rs1_addr = '0; rs2_addr = '0;

        // Busy is forced while reset is held, regardless of the sweep option.
        apply_stimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        expect_val("busy_in_rst_a", 32'd1);
        expect_val("busy_in_rst_d", 32'd1);
        #2;
        check_output(32'(busy[0]));
        check_output(32'(busy[3]));

        // First sweep, interrupted after ten cycles.
        for (int i = 0; i < 10; i++) begin
            idle(5'd0, 5'd0);
            expect_val("busy_sweep_a", 32'd1);
            if (i == 0) expect_val("busy_noclr_d", 32'd0);
            #2;
            check_output(32'(busy[0]));
            if (i == 0) check_output(32'(busy[3]));
        end

        // Restart the sweep and count busy cycles; poke x9 mid-sweep.
        apply_stimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 40; i++) begin
            if (i == 3) begin
                apply_stimulus(1'b0, 1'b1, 5'd9, 32'hFFFF_FFFF, 1'b1, 5'd9, 5'd9, 5'd9);
                expect_val("busy_read_data", 32'h0);
                expect_val("busy_read_pend", 32'd0);
            end else begin
                idle(5'd9, 5'd9);
            end
            #2;
            if (i == 3) begin
                check_output(d1[0]);
                check_output(32'(p1[0]));
            end
            if (busy[0]) cnt_a++;
            if (busy[1]) cnt_b++;
            if (busy[2]) cnt_c++;
            if (busy[3]) cnt_d++;
        end
        expect_val("busy_len_a", 32'd32);
        expect_val("busy_len_b", 32'd32);
        expect_val("busy_len_c", 32'd24);
        expect_val("busy_len_d", 32'd0);
        check_output(32'(cnt_a));
        check_output(32'(cnt_b));
        check_output(32'(cnt_c));
        check_output(32'(cnt_d));

        // Gated write/alloc left no trace; the non-sweeping instance took it.
        idle(5'd9, 5'd9);
        expect_val("x9_after_busy_a", 32'h0);
        expect_val("x9_pend_after_busy_a", 32'd0);
        expect_val("x9_after_busy_b", 32'h0);
        expect_val("x9_ready_write_d", 32'hFFFF_FFFF);
        expect_val("x9_alloc_wins_d", 32'd1);
        #2;
        check_output(d1[0]);
        check_output(32'(p1[0]));
        check_output(d2[1]);
        check_output(d1[3]);
        check_output(32'(p1[3]));

        // Every entry reads zero after the sweep.
        for (int i = 0; i < 32; i++) begin
            idle(5'(i), 5'(i));
            expect_val($sformatf("swept_a_x%0d", i), 32'h0);
            expect_val($sformatf("swept_b_x%0d", i), 32'h0);
            #2;
            check_output(d1[0]);
            check_output(d2[1]);
        end

        // Write then read x5.
        apply_stimulus(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd5, 5'd5);
        expect_val("x5_bypass_a", 32'hDEAD_BEEF);
        expect_val("x5_old_b", 32'h0);
        #2;
        check_output(d1[0]);
        check_output(d1[1]);
        idle(5'd5, 5'd5);
        expect_val("x5_read_a", 32'hDEAD_BEEF);
        expect_val("x5_read_b", 32'hDEAD_BEEF);
        #2;
        check_output(d1[0]);
        check_output(d1[1]);

        // Write to x0: dropped with the zero register, kept without it.
        apply_stimulus(1'b0, 1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 5'd0, 5'd0);
        expect_val("x0_write_cycle_a", 32'h0);
        #2;
        check_output(d1[0]);
        idle(5'd0, 5'd0);
        expect_val("x0_read_a", 32'h0);
        expect_val("x0_read_b", 32'h0000_1234);
        #2;
        check_output(d1[0]);
        check_output(d1[1]);

        // Both ports bypass together; no-bypass instance lags one cycle.
        apply_stimulus(1'b0, 1'b1, 5'd7, 32'hA5A5_A5A5, 1'b0, 5'd0, 5'd7, 5'd7);
        expect_val("x7_byp_rs1_a", 32'hA5A5_A5A5);
        expect_val("x7_byp_rs2_a", 32'hA5A5_A5A5);
        expect_val("x7_old_rs1_b", 32'h0);
        expect_val("x7_old_rs2_b", 32'h0);
        #2;
        check_output(d1[0]);
        check_output(d2[0]);
        check_output(d1[1]);
        check_output(d2[1]);
        idle(5'd7, 5'd7);
        expect_val("x7_new_rs1_b", 32'hA5A5_A5A5);
        expect_val("x7_new_rs2_b", 32'hA5A5_A5A5);
        #2;
        check_output(d1[1]);
        check_output(d2[1]);

        // Scoreboard: alloc, then write clears.
        apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd3);
        expect_val("x3_pend_alloc_cycle_a", 32'd0);
        #2;
        check_output(32'(p1[0]));
        idle(5'd3, 5'd3);
        expect_val("x3_pend_rs1_a", 32'd1);
        expect_val("x3_pend_rs2_a", 32'd1);
        expect_val("x3_pend_rs1_b", 32'd1);
        #2;
        check_output(32'(p1[0]));
        check_output(32'(p2[0]));
        check_output(32'(p1[1]));
        apply_stimulus(1'b0, 1'b1, 5'd3, 32'h0000_0033, 1'b0, 5'd0, 5'd3, 5'd3);
        expect_val("x3_pend_wr_cycle_a", 32'd0);
        expect_val("x3_pend_wr_cycle_b", 32'd1);
        #2;
        check_output(32'(p1[0]));
        check_output(32'(p1[1]));
        idle(5'd3, 5'd3);
        expect_val("x3_pend_after_wr_a", 32'd0);
        expect_val("x3_pend_after_wr_b", 32'd0);
        #2;
        check_output(32'(p1[0]));
        check_output(32'(p1[1]));

        // Alloc and write to the same register: allocation wins.
        apply_stimulus(1'b0, 1'b1, 5'd3, 32'h0000_0044, 1'b1, 5'd3, 5'd3, 5'd3);
        idle(5'd3, 5'd3);
        expect_val("x3_alloc_wins_a", 32'd1);
        expect_val("x3_alloc_wins_b", 32'd1);
        expect_val("x3_data_a", 32'h0000_0044);
        #2;
        check_output(32'(p1[0]));
        check_output(32'(p1[1]));
        check_output(d1[0]);
        apply_stimulus(1'b0, 1'b1, 5'd3, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3);

        // Alloc of x0 only sticks without the zero register.
        apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        expect_val("x0_pend_a", 32'd0);
        expect_val("x0_pend_b", 32'd1);
        #2;
        check_output(32'(p1[0]));
        check_output(32'(p1[1]));

        // Address 30: out of range for the 24-entry instance only.
        apply_stimulus(1'b0, 1'b1, 5'd30, 32'h0000_5555, 1'b1, 5'd30, 5'd30, 5'd6);
        idle(5'd30, 5'd6);
        expect_val("oor_read_c", 32'h0);
        expect_val("oor_pend_c", 32'd0);
        expect_val("oor_alias_x6_c", 32'h0);
        expect_val("x30_read_a", 32'h0000_5555);
        expect_val("x30_pend_a", 32'd1);
        #2;
        check_output(d1[2]);
        check_output(32'(p1[2]));
        check_output(d2[2]);
        check_output(d1[0]);
        check_output(32'(p1[0]));

        // Top valid entry of the 24-entry instance.
        apply_stimulus(1'b0, 1'b1, 5'd23, 32'h0000_0077, 1'b0, 5'd0, 5'd23, 5'd23);
        expect_val("x23_bypass_c", 32'h0000_0077);
        #2;
        check_output(d1[2]);
        idle(5'd23, 5'd23);
        expect_val("x23_read_c", 32'h0000_0077);
        #2;
        check_output(d2[2]);

        total++;
        assert (sb.size() == 0)
        else begin
            bad++;
            $error("[TB] FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
